// File: rtl/pc_flag_unit.sv
// PC and flag register unit with RUN/HALT sequencing for a 16-bit ISA.
// Define PC_FLAG_BR_COUNT_EN to build the saturating taken-branch counter.
module pc_flag_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        stall,
    input  logic [3:0]  opcode,
    input  logic [2:0]  alu_flag,
    input  logic [2:0]  cond,
    input  logic [8:0]  imm9,
    input  logic [15:0] br_target,
    output logic [15:0] pc_out,
    output logic [15:0] pc_plus2,
    output logic [2:0]  flag_out,
    output logic        taken,
    output logic        halted,
    output logic [15:0] br_count
);

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_XOR = 4'b0010;
    localparam logic [3:0] OP_SLL = 4'b0100;
    localparam logic [3:0] OP_SRA = 4'b0101;
    localparam logic [3:0] OP_ROR = 4'b0110;
    localparam logic [3:0] OP_B   = 4'b1100;
    localparam logic [3:0] OP_BR  = 4'b1101;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {
        RUN,
        HALT
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [2:0]  flag_q, flag_d;
    logic        cond_true;
    logic        is_br;
    logic        commit;
    logic        fz, fv, fn;

    assign fz = flag_q[2];
    assign fv = flag_q[1];
    assign fn = flag_q[0];

    // Branch conditions always read the pre-commit flag register
    always_comb begin
        cond_true = 1'b0;
        unique case (cond)
            3'b000: cond_true = ~fz;
            3'b001: cond_true = fz;
            3'b010: cond_true = ~fz & ~fn;
            3'b011: cond_true = fn;
            3'b100: cond_true = fz | (~fz & ~fn);
            3'b101: cond_true = fz | fn;
            3'b110: cond_true = fv;
            3'b111: cond_true = 1'b1;
            default: cond_true = 1'b0;
        endcase
    end

    assign is_br    = (opcode == OP_B) || (opcode == OP_BR);
    assign taken    = (state_q == RUN) & valid_in & is_br & cond_true;
    assign commit   = (state_q == RUN) & valid_in & ~stall;
    assign pc_plus2 = pc_q + 16'd2;
    assign pc_out   = pc_q;
    assign flag_out = flag_q;
    assign halted   = (state_q == HALT);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
        if (commit) begin
            pc_d = pc_plus2;
            unique case (opcode)
                OP_ADD, OP_SUB: flag_d = alu_flag;
                OP_XOR, OP_SLL, OP_SRA, OP_ROR: flag_d[2] = alu_flag[2];
                OP_B: begin
                    if (taken)
                        pc_d = pc_plus2 + {{6{imm9[8]}}, imm9, 1'b0};
                end
                OP_BR: begin
                    if (taken)
                        pc_d = br_target;
                end
                OP_HLT: begin
                    pc_d    = pc_q;
                    state_d = HALT;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            pc_q    <= 16'h0000;
            flag_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
        end
    end

`ifdef PC_FLAG_BR_COUNT_EN
    logic [15:0] bc_q, bc_d;

    always_comb begin
        bc_d = bc_q;
        if (commit && taken && (bc_q != 16'hFFFF))
            bc_d = bc_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            bc_q <= 16'h0000;
        else
            bc_q <= bc_d;
    end

    assign br_count = bc_q;
`else
    assign br_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pc_flag_unit.sv
// Scoreboard bench for pc_flag_unit: directed cycles push expectations,
// a negedge monitor pops and compares them.
module tb_pc_flag_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        stall;
    logic [3:0]  opcode;
    logic [2:0]  alu_flag;
    logic [2:0]  cond;
    logic [8:0]  imm9;
    logic [15:0] br_target;
    logic [15:0] pc_out;
    logic [15:0] pc_plus2;
    logic [2:0]  flag_out;
    logic        taken;
    logic        halted;
    logic [15:0] br_count;

    pc_flag_unit dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .stall     (stall),
        .opcode    (opcode),
        .alu_flag  (alu_flag),
        .cond      (cond),
        .imm9      (imm9),
        .br_target (br_target),
        .pc_out    (pc_out),
        .pc_plus2  (pc_plus2),
        .flag_out  (flag_out),
        .taken     (taken),
        .halted    (halted),
        .br_count  (br_count)
    );

    typedef struct {
        int          row;
        logic [15:0] pc;
        logic [2:0]  fl;
        logic        h;
        logic        tk;
        logic [15:0] bc;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   row_no = 0;
    bit   done   = 0;

    localparam logic [3:0] ADD = 4'b0000;
    localparam logic [3:0] SUB = 4'b0001;
    localparam logic [3:0] XOR = 4'b0010;
    localparam logic [3:0] SLL = 4'b0100;
    localparam logic [3:0] LW  = 4'b1000;
    localparam logic [3:0] B   = 4'b1100;
    localparam logic [3:0] BR  = 4'b1101;
    localparam logic [3:0] HLT = 4'b1111;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int row,
                       input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL row%0d %s: got %h expected %h", row, nm, act, exp);
    endtask

    // Monitor: the DUT presents a registered state every cycle
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("pc_out", e.row, pc_out, e.pc);
                chk("pc_plus2", e.row, pc_plus2, e.pc + 16'd2);
                chk("flag_out", e.row, {13'd0, flag_out}, {13'd0, e.fl});
                chk("halted", e.row, {15'd0, halted}, {15'd0, e.h});
                chk("taken", e.row, {15'd0, taken}, {15'd0, e.tk});
`ifdef PC_FLAG_BR_COUNT_EN
                chk("br_count", e.row, br_count, e.bc);
`else
                chk("br_count", e.row, br_count, 16'h0000);
`endif
            end
        end
    end

    // One cycle of stimulus plus the hand-computed outputs for that cycle
    task automatic cyc(input logic r, input logic v, input logic st,
                       input logic [3:0] op, input logic [2:0] af,
                       input logic [2:0] cd, input logic [8:0] im,
                       input logic [15:0] tg, input bit ck,
                       input logic [15:0] epc, input logic [2:0] efl,
                       input logic eh, input logic etk,
                       input logic [15:0] ebc);
        exp_t e;
        @(posedge clk);
        #1;
        rst       = r;
        valid_in  = v;
        stall     = st;
        opcode    = op;
        alu_flag  = af;
        cond      = cd;
        imm9      = im;
        br_target = tg;
        row_no++;
        if (ck) begin
            e.row = row_no;
            e.pc  = epc;
            e.fl  = efl;
            e.h   = eh;
            e.tk  = etk;
            e.bc  = ebc;
            q.push_back(e);
        end
    endtask

    initial begin
        rst = 1'b1; valid_in = 1'b0; stall = 1'b0; opcode = ADD;
        alu_flag = 3'b000; cond = 3'b000; imm9 = 9'h000;
        br_target = 16'h0000;
        //  r  v  s  op   alu     cond    imm     tgt       ck pc       fl      h  tk bc
        cyc(1, 1, 0, ADD, 3'b000, 3'b000, 9'h000, 16'h0000, 0, 16'h0000, 3'b000, 0, 0, 16'd0);
        cyc(0, 1, 0, ADD, 3'b001, 3'b000, 9'h000, 16'h0000, 1, 16'h0000, 3'b000, 0, 0, 16'd0);
        cyc(0, 1, 0, ADD, 3'b010, 3'b000, 9'h000, 16'h0000, 1, 16'h0002, 3'b001, 0, 0, 16'd0);
        cyc(0, 1, 0, ADD, 3'b011, 3'b000, 9'h000, 16'h0000, 1, 16'h0004, 3'b010, 0, 0, 16'd0);
        cyc(0, 0, 0, ADD, 3'b111, 3'b000, 9'h000, 16'h0000, 1, 16'h0006, 3'b011, 0, 0, 16'd0);
        cyc(0, 1, 0, ADD, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'h0006, 3'b011, 0, 0, 16'd0);
        cyc(0, 1, 0, XOR, 3'b111, 3'b000, 9'h000, 16'h0000, 1, 16'h0008, 3'b000, 0, 0, 16'd0);
        cyc(0, 1, 0, ADD, 3'b011, 3'b000, 9'h000, 16'h0000, 1, 16'h000A, 3'b100, 0, 0, 16'd0);
        cyc(0, 1, 1, SUB, 3'b110, 3'b000, 9'h000, 16'h0000, 1, 16'h000C, 3'b011, 0, 0, 16'd0);
        cyc(0, 1, 0, LW,  3'b111, 3'b000, 9'h000, 16'h0000, 1, 16'h000C, 3'b011, 0, 0, 16'd0);
        cyc(0, 1, 0, SLL, 3'b100, 3'b000, 9'h000, 16'h0000, 1, 16'h000E, 3'b011, 0, 0, 16'd0);
        cyc(0, 1, 0, B,   3'b000, 3'b001, 9'h1FE, 16'h0000, 1, 16'h0010, 3'b111, 0, 1, 16'd0);
        cyc(0, 1, 0, ADD, 3'b100, 3'b000, 9'h000, 16'h0000, 1, 16'h000E, 3'b111, 0, 0, 16'd1);
        cyc(0, 1, 0, B,   3'b000, 3'b000, 9'h1FE, 16'h0000, 1, 16'h0010, 3'b100, 0, 0, 16'd1);
        cyc(0, 1, 1, B,   3'b000, 3'b001, 9'h005, 16'h0000, 1, 16'h0012, 3'b100, 0, 1, 16'd1);
        cyc(0, 1, 0, B,   3'b000, 3'b001, 9'h005, 16'h0000, 1, 16'h0012, 3'b100, 0, 1, 16'd1);
        cyc(0, 1, 0, BR,  3'b000, 3'b111, 9'h000, 16'hFFFE, 1, 16'h001E, 3'b100, 0, 1, 16'd2);
        cyc(0, 1, 0, ADD, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'hFFFE, 3'b100, 0, 0, 16'd3);
        cyc(0, 1, 0, BR,  3'b000, 3'b111, 9'h000, 16'h1234, 1, 16'h0000, 3'b000, 0, 1, 16'd3);
        cyc(0, 1, 0, B,   3'b000, 3'b010, 9'h000, 16'h0000, 1, 16'h1234, 3'b000, 0, 1, 16'd4);
        cyc(0, 1, 0, B,   3'b000, 3'b110, 9'h000, 16'h0000, 1, 16'h1236, 3'b000, 0, 0, 16'd5);
        cyc(0, 0, 0, B,   3'b000, 3'b111, 9'h000, 16'h0000, 1, 16'h1238, 3'b000, 0, 0, 16'd5);
        cyc(0, 1, 0, BR,  3'b000, 3'b111, 9'h000, 16'h0020, 1, 16'h1238, 3'b000, 0, 1, 16'd5);
        cyc(0, 1, 1, HLT, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'h0020, 3'b000, 0, 0, 16'd6);
        cyc(0, 1, 1, HLT, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'h0020, 3'b000, 0, 0, 16'd6);
        cyc(0, 1, 0, HLT, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'h0020, 3'b000, 0, 0, 16'd6);
        for (int i = 0; i < 9; i++)
            cyc(0, 1, 0, ADD, 3'b111, 3'b000, 9'h000, 16'h0000, 1, 16'h0020, 3'b000, 1, 0, 16'd6);
        cyc(0, 1, 0, B,   3'b111, 3'b111, 9'h010, 16'h0000, 1, 16'h0020, 3'b000, 1, 0, 16'd6);
        cyc(1, 1, 1, HLT, 3'b000, 3'b111, 9'h000, 16'h0000, 1, 16'h0020, 3'b000, 1, 0, 16'd6);
        cyc(0, 1, 0, ADD, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'h0000, 3'b000, 0, 0, 16'd0);
        cyc(0, 1, 0, BR,  3'b000, 3'b101, 9'h000, 16'h5555, 1, 16'h0002, 3'b000, 0, 0, 16'd0);
        cyc(0, 1, 0, ADD, 3'b001, 3'b000, 9'h000, 16'h0000, 1, 16'h0004, 3'b000, 0, 0, 16'd0);
        cyc(0, 1, 0, B,   3'b000, 3'b101, 9'h100, 16'h0000, 1, 16'h0006, 3'b001, 0, 1, 16'd0);
        cyc(0, 1, 0, B,   3'b000, 3'b100, 9'h000, 16'h0000, 1, 16'hFE08, 3'b001, 0, 0, 16'd1);
        cyc(0, 1, 0, ADD, 3'b000, 3'b000, 9'h000, 16'h0000, 1, 16'hFE0A, 3'b001, 0, 0, 16'd1);
        done = 1;
    end

    initial begin
        int budget;
        budget = 0;
        wait (done);
        while (q.size() > 0 && budget < 10) begin
            @(negedge clk);
            budget++;
        end
        #1;
        if (q.size() > 0) begin
            n_chk++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation bound reached");
        $display("%0d/%0d checks passed", n_pass, n_chk + 1);
        $finish;
    end

endmodule

// File: doc/pc_flag_unit.md
PC_FLAG_UNIT -- requirements
Module: pc_flag_unit

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset.
REQ-003 valid_in  input  1  current opcode/operands are a real instruction.
REQ-004 stall  input  1  freeze all state this cycle.
REQ-005 opcode  input  4  instruction opcode (ADD=0000 .. HLT=1111 ISA encoding).
REQ-006 alu_flag  input  3  ALU flags this cycle: [2]=Z, [1]=V, [0]=N.
REQ-007 cond  input  3  branch condition code from instruction.
REQ-008 imm9  input  9  signed branch offset in instructions (B).
REQ-009 br_target  input  16  register-sourced target (BR).
REQ-010 pc_out  output  16  current PC register.
REQ-011 pc_plus2  output  16  pc_out+2 mod 2^16, combinational (PCS writeback).
REQ-012 flag_out  output  3  flag register, same bit order as alu_flag.
REQ-013 taken  output  1  combinational: current B/BR instruction is taken.
REQ-014 halted  output  1  high while FSM is in HALT.
REQ-015 br_count  output  16  taken-branch counter (see Configuration).

Function
REQ-016 FSM states RUN, HALT; RUN->HALT on edge where valid_in=1, stall=0, opcode=1111; HALT exits only via rst.
REQ-017 An instruction "commits" on an edge where state=RUN, valid_in=1, stall=0; no state changes otherwise.
REQ-018 Commit of ADD/SUB: flag register <= alu_flag (all three bits).
REQ-019 Commit of XOR/SLL/SRA/ROR: Z <= alu_flag[2]; V, N hold.
REQ-020 All other opcodes: flag register holds; alu_flag ignored.
REQ-021 Condition uses registered flag_out (pre-commit value): 000 Z=0; 001 Z=1; 010 Z=0&N=0; 011 N=1; 100 Z=1|(Z=0&N=0); 101 Z=1|N=1; 110 V=1; 111 always.
REQ-022 taken = state RUN & valid_in & opcode in {1100,1101} & condition true; independent of stall.
REQ-023 Next PC on commit: B taken -> pc+2+(sign_ext(imm9)<<1); BR taken -> br_target; HLT -> pc (held); else pc+2; all mod 2^16, wrap silently.
REQ-024 Commit with valid_in=0 (bubble) or stall=1: pc holds.
REQ-025 In HALT: pc_out, flag_out, br_count frozen; taken=0; halted=1.
REQ-026 No output latency beyond one register: pc_out/flag_out reflect commit on the following cycle.

Reset
REQ-027 rst=1 at edge: pc_out=0x0000, flag_out=000, state=RUN, halted=0, br_count=0; rst overrides stall, valid_in and HALT.
REQ-028 Reset mid-HALT returns to RUN at pc 0x0000 on the next edge.

Configuration
REQ-029 Macro PC_FLAG_BR_COUNT_EN: defined -> br_count increments on each committed taken B/BR, saturating at 0xFFFF; undefined -> br_count tied to 0x0000, no counter register.

Verification
REQ-030 Reset then 3 committed ADD bubbles-free -> pc_out 0x0000,0x0002,0x0004,0x0006; flags=alu_flag of last ADD.
REQ-031 flags=000, commit XOR with alu_flag=111 -> flag_out=100; then ADD with alu_flag=011 -> flag_out=011.
REQ-032 pc=0x0010, flag Z=1, B cond=001 imm9=0x1FE (-2) -> taken=1, pc_out=0x000E; cond=000 -> taken=0, pc_out=0x0012.
REQ-033 pc=0xFFFE, ADD commit -> pc_out=0x0000; BR cond=111 br_target=0x1234 -> pc_out=0x1234, br_count+1 when macro defined, 0 otherwise.
REQ-034 pc=0x0020, HLT with stall=1 for 2 cycles -> still RUN, pc 0x0020; stall=0 -> halted=1, pc_out=0x0020 held 10 cycles with ADD inputs; rst -> pc 0x0000, halted=0.
